// File: rtl/gecko_reg_scoreboard_pkg.sv
// gecko_reg_scoreboard_pkg: register address and status types used by the scoreboard
package rv32;
    typedef logic [4:0] rv32_reg_addr_t;
endpackage

package gecko;
    typedef logic [1:0] gecko_reg_status_t;
    localparam gecko_reg_status_t GECKO_REG_STATUS_VALID = 2'd0;
    localparam gecko_reg_status_t GECKO_REG_STATUS_FULL  = 2'd3;
endpackage

// File: rtl/gecko_sat_counter.sv
// gecko_sat_counter: saturating up/down counter reporting applied steps and dropped over/underflows
module gecko_sat_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         up,
    output logic         dn,
    output logic         ovf,
    output logic         unf
);
    logic [W-1:0] count_q, count_d;

    // a simultaneous inc and dec cancels, so it can neither step nor saturate
    always_comb begin
        up      = inc && !dec && count_q != '1;
        dn      = dec && !inc && count_q != '0;
        ovf     = inc && !dec && count_q == '1;
        unf     = dec && !inc && count_q == '0;
        count_d = up ? count_q + W'(1) : dn ? count_q - W'(1) : count_q;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) count_q <= '0;
        else      count_q <= count_d;

    assign count = count_q;
endmodule

// File: rtl/gecko_reg_scoreboard.sv
// gecko_reg_scoreboard: per-register outstanding-write tracker for decode hazard checks
module gecko_reg_scoreboard
    import gecko::*;
    import rv32::*;
#(
    parameter int COUNTER_WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     reserve_valid,
    input  rv32_reg_addr_t           reserve_addr,
    input  logic                     retire_valid,
    input  rv32_reg_addr_t           retire_addr,
    input  rv32_reg_addr_t           rs1_addr,
    input  rv32_reg_addr_t           rs2_addr,
    input  rv32_reg_addr_t           rd_addr,
    output logic [COUNTER_WIDTH-1:0] rs1_status,
    output logic [COUNTER_WIDTH-1:0] rs2_status,
    output logic [COUNTER_WIDTH-1:0] rd_status,
    output logic [6:0]               outstanding,
    output logic                     idle,
    output logic                     error
);
    logic [COUNTER_WIDTH-1:0] cnt [32];
    logic [31:0] up, dn, ovf, unf;
    logic [6:0] outstanding_q, outstanding_d;
    logic idle_q, idle_d, error_q, error_d;

    // x0 has no counter: it reads VALID and never steps or flags
    assign cnt[0] = COUNTER_WIDTH'(GECKO_REG_STATUS_VALID);
    assign up[0]  = 1'b0;
    assign dn[0]  = 1'b0;
    assign ovf[0] = 1'b0;
    assign unf[0] = 1'b0;

    for (genvar i = 1; i < 32; i++) begin : g_reg
        gecko_sat_counter #(.W(COUNTER_WIDTH)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (reserve_valid && reserve_addr == 5'(i)),
            .dec   (retire_valid && retire_addr == 5'(i)),
            .count (cnt[i]),
            .up    (up[i]),
            .dn    (dn[i]),
            .ovf   (ovf[i]),
            .unf   (unf[i])
        );
    end

    always_comb begin
        outstanding_d = outstanding_q + 7'(|up) - 7'(|dn);
        idle_d        = outstanding_d == '0;
        error_d       = error_q || |ovf || |unf;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            outstanding_q <= '0;
            idle_q        <= 1'b1;
            error_q       <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            idle_q        <= idle_d;
            error_q       <= error_d;
        end

    assign rs1_status  = cnt[rs1_addr];
    assign rs2_status  = cnt[rs2_addr];
    assign rd_status   = cnt[rd_addr];
    assign outstanding = outstanding_q;
    assign idle        = idle_q;
    assign error       = error_q;
endmodule

// File: tb/tb_gecko_reg_scoreboard.sv
// tb_gecko_reg_scoreboard: queue scoreboard bench for the register scoreboard
module tb_gecko_reg_scoreboard;
    logic       clk, rst;
    logic       reserve_valid, retire_valid;
    logic [4:0] reserve_addr, retire_addr, rs1_addr, rs2_addr, rd_addr;
    logic [1:0] rs1_status, rs2_status, rd_status;
    logic [6:0] outstanding;
    logic       idle, error;

    typedef struct {
        logic [1:0] s1, s2, s3;
        logic [6:0] o;
        logic       e;
        string      nm;
    } exp_t;

    exp_t q[$];
    int total = 0, passed = 0;
    logic [1:0] mdl [32];
    int mout;
    logic merr;

    gecko_reg_scoreboard dut (
        .clk(clk), .rst(rst),
        .reserve_valid(reserve_valid), .reserve_addr(reserve_addr),
        .retire_valid(retire_valid), .retire_addr(retire_addr),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .rs1_status(rs1_status), .rs2_status(rs2_status), .rd_status(rd_status),
        .outstanding(outstanding), .idle(idle), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    always @(negedge clk)
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.nm, 32'({rs1_status, rs2_status, rd_status, outstanding, idle, error}),
                32'({e.s1, e.s2, e.s3, e.o, e.o == 7'd0, e.e}));
        end

    // called at posedge+1; drives one cycle of strobes, then points lookups at the registers to inspect
    task automatic step(input logic rv, input logic [4:0] ra, input logic tv, input logic [4:0] ta,
                        input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
                        input logic [1:0] s1, input logic [1:0] s2, input logic [1:0] s3,
                        input logic [6:0] o, input logic e, input string nm);
        reserve_valid = rv; reserve_addr = ra; retire_valid = tv; retire_addr = ta;
        @(posedge clk); #1;
        reserve_valid = 1'b0; retire_valid = 1'b0;
        rs1_addr = a1; rs2_addr = a2; rd_addr = a3;
        q.push_back('{s1: s1, s2: s2, s3: s3, o: o, e: e, nm: nm});
    endtask

    task automatic d(input logic rv, input logic [4:0] ra, input logic tv, input logic [4:0] ta,
                     input logic [4:0] a, input logic [1:0] s, input logic [6:0] o, input logic e,
                     input string nm);
        step(rv, ra, tv, ta, a, a, a, s, s, s, o, e, nm);
    endtask

    task automatic mstep(input logic rv, input logic [4:0] ra, input logic tv, input logic [4:0] ta,
                         input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
                         input string nm);
        if (!(rv && tv && ra == ta)) begin
            if (rv && ra != 0) begin
                if (mdl[ra] == 2'd3) merr = 1'b1;
                else begin mdl[ra] = mdl[ra] + 2'd1; mout++; end
            end
            if (tv && ta != 0) begin
                if (mdl[ta] == 2'd0) merr = 1'b1;
                else begin mdl[ta] = mdl[ta] - 2'd1; mout--; end
            end
        end
        step(rv, ra, tv, ta, a1, a2, a3, mdl[a1], mdl[a2], mdl[a3], 7'(mout), merr, nm);
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        rst = 1'b1;
        foreach (mdl[i]) mdl[i] = 2'd0;
        mout = 0; merr = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b0;
        reserve_valid = 1'b0; retire_valid = 1'b0;
        reserve_addr = '0; retire_addr = '0;
        rs1_addr = '0; rs2_addr = '0; rd_addr = '0;
        foreach (mdl[i]) mdl[i] = 2'd0;
        mout = 0; merr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 32; i += 3)
            step(0, 0, 0, 0, 5'(i), 5'(i + 1), 5'(i + 2), 0, 0, 0, 0, 0, "reset_read");

        d(1, 5, 0, 0, 5, 1, 1, 0, "res_x5_1");
        d(1, 5, 0, 0, 5, 2, 2, 0, "res_x5_2");
        d(1, 5, 0, 0, 5, 3, 3, 0, "res_x5_3");
        d(1, 5, 0, 0, 5, 3, 3, 1, "res_x5_overflow");
        d(0, 0, 1, 5, 5, 2, 2, 1, "ret_x5_err_sticky");

        do_reset();
        d(1, 7, 0, 0, 7, 1, 1, 0, "res_x7_1");
        d(1, 7, 0, 0, 7, 2, 2, 0, "res_x7_2");
        d(1, 7, 0, 0, 7, 3, 3, 0, "res_x7_3");
        d(1, 7, 1, 7, 7, 3, 3, 0, "resret_x7_full");
        d(1, 9, 1, 9, 9, 0, 3, 0, "resret_x9_empty");
        d(1, 0, 0, 0, 0, 0, 3, 0, "res_x0");
        d(0, 0, 1, 0, 0, 0, 3, 0, "ret_x0");
        d(1, 0, 1, 0, 0, 0, 3, 0, "resret_x0");
        step(1, 10, 1, 7, 10, 7, 0, 1, 2, 0, 3, 0, "res_x10_ret_x7");
        d(0, 0, 1, 12, 12, 0, 3, 1, "ret_x12_underflow");
        step(0, 0, 0, 0, 7, 10, 12, 2, 1, 0, 3, 1, "err_sticky");

        do_reset();
        for (int n = 0; n < 1000; n++) begin
            logic rv, tv;
            logic [4:0] ra, ta;
            ra = 5'($urandom_range(0, 31));
            ta = 5'($urandom_range(1, 31));
            rv = $urandom_range(0, 1) == 1 && mdl[ra] != 2'd3;
            tv = $urandom_range(0, 1) == 1 && mdl[ta] != 2'd0;
            mstep(rv, ra, tv, ta, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), "random");
        end
        for (int r = 1; r < 32; r++)
            while (mdl[r] != 2'd0) mstep(0, 0, 1, 5'(r), 5'(r), 5'(r), 0, "drain");
        for (int i = 0; i < 32; i += 3)
            mstep(0, 0, 0, 0, 5'(i), 5'(i + 1), 5'(i + 2), "drained_read");

        for (int r = 1; r <= 17; r++)
            mstep(1, 5'(r), 0, 0, 1, 2, 3, "build17");
        mstep(0, 0, 1, 20, 1, 2, 3, "build17_err");
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        chk("async_outstanding", 32'(outstanding), 32'd0);
        chk("async_idle", 32'(idle), 32'd1);
        chk("async_error", 32'(error), 32'd0);
        chk("async_status", 32'({rs1_status, rs2_status, rd_status}), 32'd0);
        #2;
        rst = 1'b1;

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            total++;
            $display("FAIL queue_drain: %0d entries left, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/gecko_reg_scoreboard.md
# gecko_reg_scoreboard

Per-register outstanding-write tracker for the gecko core. Sits beside the decode stage: decode reserves a destination register when it issues a writeback-producing instruction, and the writeback stage retires it when the result is written. The block returns the `gecko_reg_status_t` of the rs1/rs2/rd addresses that decode uses for its readable and writeable hazard checks.

## Interface
- `COUNTER_WIDTH`, default 2: width of each per-register counter; must equal `$bits(gecko_reg_status_t)`.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `reserve_valid`  in  1  decode issues an instruction that writes back this cycle.
- `reserve_addr`  in  5  destination register (`rv32_reg_addr_t`) being reserved.
- `retire_valid`  in  1  writeback commits a result this cycle.
- `retire_addr`  in  5  register being retired.
- `rs1_addr`, `rs2_addr`, `rd_addr`  in  5 each  decode lookup addresses.
- `rs1_status`, `rs2_status`, `rd_status`  out  `COUNTER_WIDTH` each  status of the corresponding register.
- `outstanding`  out  7  total outstanding writes across all registers, range 0..93.
- `idle`  out  1  high when `outstanding == 0`.
- `error`  out  1  sticky protocol-violation flag.

## Operation
- State: 31 counters for x1..x31. x0 is never tracked, and its status always reads `GECKO_REG_STATUS_VALID` (0).
- Counter encoding: 0 = `GECKO_REG_STATUS_VALID`; max (3) = `GECKO_REG_STATUS_FULL`; values in between mean partially occupied.
- Reserve (`reserve_valid` and addr != 0): counter +1.
- Retire (`retire_valid` and addr != 0): counter -1.
- Reserve and retire to the same register in the same cycle: the counter is unchanged, with no error even if it is FULL or VALID.
- Reserve and retire to different registers: both apply independently.
- Reserve to a FULL counter, not cancelled by a same-cycle retire: the update is dropped, the counter stays at max, and `error` is set.
- Retire to a VALID counter, not cancelled by a same-cycle reserve: the update is dropped, the counter stays at 0, and `error` is set.
- Reserve or retire to x0: ignored, no error.
- `outstanding` is the sum of all counter deltas actually applied.
  - It is a registered running count, not a combinational popcount.
  - Deltas per cycle are in {-1, 0, +1, net 0}.
  - Dropped updates do not change it.
- `error` is sticky and cleared only by reset.
- Lookup outputs are a combinational mux of the registered counters.
  - No same-cycle bypass: a reserve or retire in cycle N is visible on the status outputs in cycle N+1.
  - Decode accounts for its own issue through its execute-saved register.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert by the system): all counters 0, `outstanding` = 0, `idle` = 1, `error` = 0.
  - Status outputs read 0 while in reset.
- Reset asserted mid-operation discards all outstanding reservations immediately. Writebacks still in flight are then expected to be flushed by their own stages' reset.
- Latency from update to visible status is 1 cycle. Lookup from address to status is 0 cycles (combinational).
- `idle` and `error` are registered; they change the cycle after the causing update.
- No backpressure: reserve and retire are single-cycle valid-only strobes that are always accepted.

## Structure
- `gecko_reg_status_t`, `GECKO_REG_STATUS_VALID` and `GECKO_REG_STATUS_FULL` live in package `gecko`.
- `rv32_reg_addr_t` lives in `rv32`.
- No new package types are needed.
- One sub-module is natural: `gecko_sat_counter`, a single up/down counter with saturation detect and an overflow/underflow flag. Instantiate it ×31 via generate.
- The top level does address decode, the x0 masking, the lookup muxes, the `outstanding` accumulator and the sticky `error`.

## Test plan
- Reset, then read all 32 registers → every status = 0, `idle` = 1, `error` = 0.
- Reserve x5 three cycles in a row → x5 status 1, 2, 3 (FULL) in successive cycles; `outstanding` = 3; `idle` = 0.
- Fourth reserve of x5 → x5 stays 3, `outstanding` stays 3, `error` = 1 next cycle. Then retire x5 once → 2, and `error` stays 1.
- With x7 = 3, reserve and retire x7 in the same cycle → x7 stays 3 and `error` stays 0. Repeat with x9 = 0 → x9 stays 0, no error.
- Retire x12 while it is 0 → x12 stays 0, `error` = 1. Reserve and retire x0 any number of times → x0 reads 0 and no error.
- Random stream of 1000 reserve/retire pairs, retires never exceeding reservations, then drain all → `outstanding` returns to 0, `idle` = 1, every status = 0.
- Assert `rst` mid-stream with `outstanding` = 17 → outputs reach their reset values asynchronously, before the next clock edge.
